// File: rtl/ram_bist_pkg.sv
// -----------------------------------------------------------------------------
// ram_bist_pkg
// Shared definitions for the RAM BIST loader:
//   mode_e      - operating mode encoding carried on the 3-bit mode port
//   state_e     - controller state encoding
//   pattern_bit - one bit of the address-derived test pattern
// Optional feature macro used by the loader: RAM_BIST_ERRLOG_EN.
// -----------------------------------------------------------------------------
package ram_bist_pkg;

   typedef enum logic [2:0] {
      MODE_MANUAL  = 3'd0,
      MODE_FILL0   = 3'd1,
      MODE_FILL1   = 3'd2,
      MODE_PATTERN = 3'd3,
      MODE_VERIFY  = 3'd4,
      MODE_MARCH   = 3'd5
   } mode_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_WRITE = 3'd1,
      ST_READ  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   // Bit bit_idx of the pattern word: the address bits repeat across the
   // word, and every odd repetition is inverted.
   function automatic logic pattern_bit(input logic [31:0] addr,
                                        input int unsigned addr_w,
                                        input int unsigned bit_idx);
      logic [31:0] shifted;
      shifted = addr >> (bit_idx % addr_w);
      return shifted[0] ^ (((bit_idx / addr_w) % 2) == 32'd1);
   endfunction

endpackage

// File: rtl/ram_bist_pattern.sv
// -----------------------------------------------------------------------------
// ram_bist_pattern
// Purely combinational pattern generator: maps a RAM address to the test
// pattern word expected at that address.
// Ports:
//   addr_i    [ADDR_W-1:0]  address
//   pattern_o [DATA_W-1:0]  pattern word for that address
// -----------------------------------------------------------------------------
module ram_bist_pattern
   import ram_bist_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic [ADDR_W-1:0] addr_i,
   output logic [DATA_W-1:0] pattern_o
);

   for (genvar gi = 0; gi < DATA_W; gi++) begin : g_bit
      assign pattern_o[gi] = pattern_bit(32'(addr_i), ADDR_W, gi);
   end

endmodule

// File: rtl/ram_bist_loader.sv
// -----------------------------------------------------------------------------
// ram_bist_loader
// Fills, verifies or march-tests a synchronous single-port RAM (1-cycle read
// latency). Modes: 0 manual fill, 1 fill zeros, 2 fill ones, 3 fill pattern,
// 4 verify pattern, 5 march (fill pattern, then verify it).
// Ports:
//   clock, clear_n         clock, asynchronous active-low reset
//   start, abort, step_en  begin operation, terminate, clock enable
//   mode, manual_data      operation select, write data for manual mode
//   ram_addr/wdata/we      RAM request, ram_rdata RAM read data
//   busy, done, pass       status
//   err_count              number of verify mismatches since start
//   first_err_addr         first mismatching address (0 unless
//                          RAM_BIST_ERRLOG_EN is defined)
// Optional feature: define RAM_BIST_ERRLOG_EN to capture first_err_addr.
// -----------------------------------------------------------------------------
module ram_bist_loader
   import ram_bist_pkg::*;
#(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              clear_n,
   input  logic              start,
   input  logic              abort,
   input  logic              step_en,
   input  logic [2:0]        mode,
   input  logic [DATA_W-1:0] manual_data,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_we,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ADDR_W:0]   err_count,
   output logic [ADDR_W-1:0] first_err_addr
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   state_e            state_q;
   logic [2:0]        mode_q;
   logic [ADDR_W-1:0] addr_q;
   logic              pend_q;     // a read was issued and its data awaits compare
   logic [ADDR_W:0]   err_q;
   logic [ADDR_W-1:0] prev_addr;  // address of the read currently being compared
   logic [DATA_W-1:0] wr_pat;
   logic [DATA_W-1:0] rd_pat;
   logic              advance;
   logic              start_ok;
   logic              mismatch;

   assign prev_addr = addr_q - 1'b1;
   assign advance   = step_en & ~abort;
   assign start_ok  = start & ~abort & ((state_q == ST_IDLE) | (state_q == ST_DONE));
   assign mismatch  = advance & pend_q & ((state_q == ST_READ) | (state_q == ST_DRAIN))
                    & (ram_rdata != rd_pat);

   ram_bist_pattern #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_pat (
      .addr_i    (addr_q),
      .pattern_o (wr_pat)
   );

   ram_bist_pattern #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_rd_pat (
      .addr_i    (prev_addr),
      .pattern_o (rd_pat)
   );

   // RAM request. During a stalled read (and in DRAIN) the address of the
   // outstanding read is re-presented, so the RAM keeps returning that word
   // and the compare on the next enabled cycle sees the correct data.
   always_comb begin
      ram_we    = 1'b0;
      ram_wdata = '0;
      ram_addr  = addr_q;
      case (state_q)
         ST_WRITE: begin
            ram_we = advance;
            case (mode_q)
               MODE_MANUAL: ram_wdata = manual_data;
               MODE_FILL0:  ram_wdata = '0;
               MODE_FILL1:  ram_wdata = '1;
               default:     ram_wdata = wr_pat;
            endcase
         end
         ST_READ: begin
            if (!step_en && pend_q) ram_addr = prev_addr;
         end
         ST_DRAIN: ram_addr = prev_addr;
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n) begin
         state_q <= ST_IDLE;
         mode_q  <= 3'd0;
         addr_q  <= '0;
         pend_q  <= 1'b0;
         err_q   <= '0;
      end else if (abort) begin
         // Counters and address are held; any outstanding read is dropped.
         state_q <= ST_IDLE;
         pend_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  mode_q  <= mode;
                  addr_q  <= '0;
                  err_q   <= '0;
                  pend_q  <= 1'b0;
                  state_q <= (mode == MODE_VERIFY) ? ST_READ : ST_WRITE;
               end
            end
            ST_WRITE: begin
               if (step_en) begin
                  addr_q <= addr_q + 1'b1;   // wraps to 0 for the march read pass
                  if (addr_q == LAST_ADDR)
                     state_q <= (mode_q == MODE_MARCH) ? ST_READ : ST_DONE;
               end
            end
            ST_READ: begin
               if (step_en) begin
                  addr_q <= addr_q + 1'b1;
                  pend_q <= 1'b1;
                  if (mismatch) err_q <= err_q + 1'b1;
                  if (addr_q == LAST_ADDR) state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (step_en) begin
                  pend_q  <= 1'b0;
                  if (mismatch) err_q <= err_q + 1'b1;
                  state_q <= ST_DONE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign busy      = (state_q == ST_WRITE) | (state_q == ST_READ) | (state_q == ST_DRAIN);
   assign done      = (state_q == ST_DONE);
   assign pass      = done & (err_q == '0) & ((mode_q == MODE_VERIFY) | (mode_q == MODE_MARCH));
   assign err_count = err_q;

`ifdef RAM_BIST_ERRLOG_EN
   logic [ADDR_W-1:0] first_err_q;

   // Captured only while the error count is still zero, i.e. on the first mismatch.
   always_ff @(posedge clock or negedge clear_n) begin
      if (!clear_n)
         first_err_q <= '0;
      else if (start_ok)
         first_err_q <= '0;
      else if (mismatch && (err_q == '0))
         first_err_q <= prev_addr;
   end

   assign first_err_addr = first_err_q;
`else
   assign first_err_addr = '0;
`endif

endmodule

// File: tb/tb_ram_bist_loader.sv
module tb_ram_bist_loader;

   localparam int DEPTH = 16;

   logic       clock = 1'b0;
   logic       clear_n = 1'b0;
   logic       start = 1'b0;
   logic       abort = 1'b0;
   logic       step_en = 1'b0;
   logic [2:0] mode = 3'd0;
   logic [7:0] manual_data = 8'h00;
   logic [3:0] ram_addr;
   logic [7:0] ram_wdata;
   logic       ram_we;
   logic [7:0] ram_rdata;
   logic       busy, done, pass;
   logic [4:0] err_count;
   logic [3:0] first_err_addr;

   logic [7:0] ram     [DEPTH];
   logic [7:0] ref_mem [DEPTH];
   logic       bk_we = 1'b0;
   logic [3:0] bk_addr = 4'd0;
   logic [7:0] bk_data = 8'h00;
   int         wr_total = 0;
   int         we_bad = 0;
   int         n_cmp = 0;
   int         n_fail = 0;

   ram_bist_loader #(.ADDR_W(4), .DATA_W(8)) dut (
      .clock          (clock),
      .clear_n        (clear_n),
      .start          (start),
      .abort          (abort),
      .step_en        (step_en),
      .mode           (mode),
      .manual_data    (manual_data),
      .ram_addr       (ram_addr),
      .ram_wdata      (ram_wdata),
      .ram_we         (ram_we),
      .ram_rdata      (ram_rdata),
      .busy           (busy),
      .done           (done),
      .pass           (pass),
      .err_count      (err_count),
      .first_err_addr (first_err_addr)
   );

   always #5 clock = ~clock;

   // Behavioural synchronous RAM with a backdoor write port for preloading.
   always @(posedge clock) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else if (bk_we) ram[bk_addr] <= bk_data;
      ram_rdata <= ram[ram_addr];
      if (ram_we) wr_total <= wr_total + 1;
   end

   always @(negedge clock) begin
      if (ram_we && (!busy || done)) we_bad <= we_bad + 1;
   end

   // Expected pattern: low nibble is the address, high nibble its inverse.
   function automatic logic [7:0] pat(input int a);
      return 8'(((15 - a) << 4) | a);
   endfunction

   task automatic poke(input int a, input logic [7:0] d);
      @(negedge clock);
      bk_we = 1'b1; bk_addr = 4'(a); bk_data = d; ref_mem[a] = d;
      @(posedge clock);
      #1 bk_we = 1'b0;
   endtask

   task automatic prefill_random();
      for (int a = 0; a < DEPTH; a++) poke(a, 8'($urandom));
   endtask

   // Reference model: updates ref_mem to the post-run contents and returns the
   // expected error count, first error address and pass flag.
   task automatic predict(input logic [2:0] m, input logic [7:0] md,
                          output int e_err, output int e_first, output bit e_pass);
      e_err = 0; e_first = 0;
      for (int a = 0; a < DEPTH; a++) begin
         case (m)
            3'd0: ref_mem[a] = md;
            3'd1: ref_mem[a] = 8'h00;
            3'd2: ref_mem[a] = 8'hFF;
            3'd3, 3'd5: ref_mem[a] = pat(a);
            default: begin
               if (ref_mem[a] !== pat(a)) begin
                  if (e_err == 0) e_first = a;
                  e_err++;
               end
            end
         endcase
      end
      e_pass = ((m == 3'd4) || (m == 3'd5)) && (e_err == 0);
`ifndef RAM_BIST_ERRLOG_EN
      e_first = 0;
`endif
   endtask

   // style 0: step_en always 1, 1: toggles 1,0,..., 2: random.
   // inject: pulse start (with mode 4) in the middle of the run.
   task automatic run_op(input logic [2:0] m, input logic [7:0] md, input int style,
                         input bit inject, output int cycles, output int writes);
      int w0;
      @(negedge clock);
      mode = m; manual_data = md; step_en = 1'b1; start = 1'b1;
      w0 = wr_total;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      cycles = 0;
      while (!done && cycles < 400) begin
         case (style)
            0:       step_en = 1'b1;
            1:       step_en = ((cycles % 2) == 0);
            default: step_en = 1'($urandom_range(0, 1));
         endcase
         if (inject && cycles == 5) begin start = 1'b1; mode = 3'd4; end
         else start = 1'b0;
         @(posedge clock);
         cycles++;
         @(negedge clock);
      end
      start = 1'b0; step_en = 1'b1;
      writes = wr_total - w0;
      n_cmp++;
      if (done !== 1'b1) begin
         n_fail++;
         $display("FAIL run_timeout: done=%b after %0d cycles, required 1", done, cycles);
      end
      $display("run mode=%0d style=%0d cycles=%0d writes=%0d err=%0d first=%0d pass=%b",
               m, style, cycles, writes, err_count, first_err_addr, pass);
   endtask

   task automatic test_reset();
      step_en = 1'b1;
      repeat (2) @(negedge clock);
      n_cmp++;
      if ({busy, done, pass, ram_we, ram_wdata, err_count, first_err_addr, ram_addr} !== 27'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: busy=%b done=%b pass=%b we=%b wdata=%h err=%0d first=%0d addr=%0d, required all 0",
                  busy, done, pass, ram_we, ram_wdata, err_count, first_err_addr, ram_addr);
      end
      clear_n = 1'b1;
      @(negedge clock);
      n_cmp++;
      if ({busy, done} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
      end
   endtask

   task automatic test_fill_pattern();
      int cyc, wr, e_err, e_first;
      bit e_pass;
      prefill_random();
      predict(3'd3, 8'h00, e_err, e_first, e_pass);
      run_op(3'd3, 8'h00, 0, 1'b0, cyc, wr);
      n_cmp++; if (cyc !== 16) begin n_fail++; $display("FAIL fill_cycles: got %0d required 16", cyc); end
      n_cmp++; if (wr !== 16) begin n_fail++; $display("FAIL fill_writes: got %0d required 16", wr); end
      n_cmp++; if (ram[0] !== 8'hF0) begin n_fail++; $display("FAIL fill_addr0: got %h required f0", ram[0]); end
      n_cmp++; if (ram[5] !== 8'hA5) begin n_fail++; $display("FAIL fill_addr5: got %h required a5", ram[5]); end
      n_cmp++; if (pass !== e_pass) begin n_fail++; $display("FAIL fill_pass: got %b required %b", pass, e_pass); end
      for (int a = 0; a < DEPTH; a++) begin
         n_cmp++;
         if (ram[a] !== ref_mem[a]) begin n_fail++; $display("FAIL fill_mem[%0d]: got %h required %h", a, ram[a], ref_mem[a]); end
      end
   endtask

   task automatic test_march();
      int cyc, wr, e_err, e_first;
      bit e_pass;
      prefill_random();
      predict(3'd5, 8'h00, e_err, e_first, e_pass);
      run_op(3'd5, 8'h00, 0, 1'b0, cyc, wr);
      n_cmp++; if (cyc !== 33) begin n_fail++; $display("FAIL march_cycles: got %0d required 33", cyc); end
      n_cmp++; if (wr !== 16) begin n_fail++; $display("FAIL march_writes: got %0d required 16", wr); end
      n_cmp++; if (pass !== 1'b1) begin n_fail++; $display("FAIL march_pass: got %b required 1", pass); end
      n_cmp++; if (err_count !== 5'(e_err)) begin n_fail++; $display("FAIL march_err: got %0d required %0d", err_count, e_err); end
      for (int a = 0; a < DEPTH; a++) begin
         n_cmp++;
         if (ram[a] !== ref_mem[a]) begin n_fail++; $display("FAIL march_mem[%0d]: got %h required %h", a, ram[a], ref_mem[a]); end
      end
   endtask

   // Memory holds the pattern; one word is corrupted, then verified with
   // continuous, toggled and random step_en.
   task automatic test_verify_corrupt();
      int cyc, wr, e_err, e_first;
      bit e_pass;
      poke(7, 8'h00);
      for (int style = 0; style < 3; style++) begin
         if (style == 2) begin
            poke($urandom_range(0, 15), 8'($urandom));
            poke($urandom_range(0, 15), 8'($urandom));
         end
         predict(3'd4, 8'h00, e_err, e_first, e_pass);
         run_op(3'd4, 8'h00, style, 1'b0, cyc, wr);
         if (style == 0) begin
            n_cmp++; if (cyc !== 17) begin n_fail++; $display("FAIL verify_cycles: got %0d required 17", cyc); end
         end
         n_cmp++; if (wr !== 0) begin n_fail++; $display("FAIL verify_writes[%0d]: got %0d required 0", style, wr); end
         n_cmp++; if (err_count !== 5'(e_err)) begin n_fail++; $display("FAIL verify_err[%0d]: got %0d required %0d", style, err_count, e_err); end
         n_cmp++; if (first_err_addr !== 4'(e_first)) begin n_fail++; $display("FAIL verify_first[%0d]: got %0d required %0d", style, first_err_addr, e_first); end
         n_cmp++; if (pass !== e_pass) begin n_fail++; $display("FAIL verify_pass[%0d]: got %b required %b", style, pass, e_pass); end
      end
      // done and the results hold while idle, whatever step_en does
      repeat (6) begin
         @(negedge clock);
         step_en = 1'($urandom_range(0, 1));
      end
      @(negedge clock);
      n_cmp++; if ({done, err_count} !== {1'b1, 5'(e_err)}) begin n_fail++; $display("FAIL done_hold: done=%b err=%0d required 1 %0d", done, err_count, e_err); end
      step_en = 1'b1;
   endtask

   task automatic test_abort();
      int w0, e_err, e_first;
      bit e_pass, found;
      predict(3'd5, 8'h00, e_err, e_first, e_pass);
      @(negedge clock);
      mode = 3'd5; step_en = 1'b1; start = 1'b1; w0 = wr_total;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      found = 1'b0;
      for (int c = 0; c < 60 && !found; c++) begin
         if (busy && !ram_we && ram_addr == 4'd9 && (wr_total - w0) == 16) found = 1'b1;
         else begin @(posedge clock); @(negedge clock); end
      end
      n_cmp++; if (found !== 1'b1) begin n_fail++; $display("FAIL abort_reach_addr9: got %b required 1", found); end
      abort = 1'b1;
      @(posedge clock);
      @(negedge clock);
      abort = 1'b0;
      n_cmp++;
      if ({busy, done, pass, ram_we, err_count} !== 9'd0) begin
         n_fail++;
         $display("FAIL abort_idle: busy=%b done=%b pass=%b we=%b err=%0d required all 0", busy, done, pass, ram_we, err_count);
      end
      start = 1'b1; abort = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0; abort = 1'b0;
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_beats_start: busy=%b required 0", busy); end
      for (int a = 0; a < DEPTH; a++) begin
         n_cmp++;
         if (ram[a] !== ref_mem[a]) begin n_fail++; $display("FAIL abort_mem[%0d]: got %h required %h", a, ram[a], ref_mem[a]); end
      end
   endtask

   task automatic test_clear_mid_write();
      @(negedge clock);
      mode = 3'd2; step_en = 1'b1; start = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start = 1'b0;
      repeat (4) begin @(posedge clock); @(negedge clock); end
      n_cmp++; if ({ram_we, ram_wdata} !== {1'b1, 8'hFF}) begin n_fail++; $display("FAIL clear_pre_write: we=%b wdata=%h required 1 ff", ram_we, ram_wdata); end
      #2 clear_n = 1'b0;
      #1;
      n_cmp++;
      if ({busy, done, pass, ram_we, ram_wdata, err_count, first_err_addr, ram_addr} !== 27'd0) begin
         n_fail++;
         $display("FAIL clear_async: busy=%b done=%b pass=%b we=%b wdata=%h err=%0d first=%0d addr=%0d required all 0",
                  busy, done, pass, ram_we, ram_wdata, err_count, first_err_addr, ram_addr);
      end
      repeat (2) @(negedge clock);
      clear_n = 1'b1;
      prefill_random();
   endtask

   task automatic test_manual_busy_start();
      int cyc, wr, e_err, e_first;
      bit e_pass;
      prefill_random();
      predict(3'd0, 8'h3C, e_err, e_first, e_pass);
      run_op(3'd0, 8'h3C, 0, 1'b1, cyc, wr);
      n_cmp++; if (cyc !== 16) begin n_fail++; $display("FAIL manual_cycles: got %0d required 16", cyc); end
      n_cmp++; if (wr !== 16) begin n_fail++; $display("FAIL manual_writes: got %0d required 16", wr); end
      n_cmp++; if ({done, pass} !== 2'b10) begin n_fail++; $display("FAIL manual_status: done=%b pass=%b required 1 0", done, pass); end
      for (int a = 0; a < DEPTH; a++) begin
         n_cmp++;
         if (ram[a] !== ref_mem[a]) begin n_fail++; $display("FAIL manual_mem[%0d]: got %h required %h", a, ram[a], ref_mem[a]); end
      end
   endtask

   task automatic test_random();
      int cyc, wr, e_err, e_first, style, e_wr, e_cyc;
      bit e_pass;
      logic [2:0] m;
      logic [7:0] md;
      for (int it = 0; it < 10; it++) begin
         m = 3'($urandom_range(0, 5));
         md = 8'($urandom);
         style = $urandom_range(0, 2);
         if (m == 3'd4 && $urandom_range(0, 1) == 1) begin
            for (int a = 0; a < DEPTH; a++) poke(a, pat(a));
            repeat ($urandom_range(1, 3)) poke($urandom_range(0, 15), 8'($urandom));
         end else begin
            prefill_random();
         end
         predict(m, md, e_err, e_first, e_pass);
         run_op(m, md, style, 1'b0, cyc, wr);
         e_wr  = (m == 3'd4) ? 0 : 16;
         e_cyc = (m == 3'd4) ? 17 : (m == 3'd5) ? 33 : 16;
         if (style == 0) begin
            n_cmp++; if (cyc !== e_cyc) begin n_fail++; $display("FAIL rand%0d_cycles: got %0d required %0d", it, cyc, e_cyc); end
         end
         n_cmp++; if (wr !== e_wr) begin n_fail++; $display("FAIL rand%0d_writes: got %0d required %0d", it, wr, e_wr); end
         n_cmp++; if (err_count !== 5'(e_err)) begin n_fail++; $display("FAIL rand%0d_err: got %0d required %0d", it, err_count, e_err); end
         n_cmp++; if (first_err_addr !== 4'(e_first)) begin n_fail++; $display("FAIL rand%0d_first: got %0d required %0d", it, first_err_addr, e_first); end
         n_cmp++; if (pass !== e_pass) begin n_fail++; $display("FAIL rand%0d_pass: got %b required %b", it, pass, e_pass); end
         for (int a = 0; a < DEPTH; a++) begin
            n_cmp++;
            if (ram[a] !== ref_mem[a]) begin n_fail++; $display("FAIL rand%0d_mem[%0d]: got %h required %h", it, a, ram[a], ref_mem[a]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill_pattern();
      test_march();
      test_verify_corrupt();
      test_abort();
      test_clear_mid_write();
      test_manual_busy_start();
      test_random();
      n_cmp++;
      if (we_bad !== 0) begin n_fail++; $display("FAIL we_outside_write: got %0d cycles required 0", we_bad); end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
